// File: rtl/dsp_pkg.sv
// Shared types and arithmetic helpers for the biquad filter datapath.
// The rounding/saturation helper takes its widths as arguments so every instance can share it.
package dsp_pkg;

  localparam int WS_DEF = 16;

  typedef logic signed [WS_DEF-1:0] dType;

  typedef enum logic [2:0] {B0 = 3'd0, B1, B2, A1, A2} coef_e;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

  typedef struct packed {
    logic signed [63:0] y;
    logic               clip;
  } rsat_t;

  // Round half up at the binary point, then clamp to a ws-bit signed range.
  function automatic rsat_t round_sat(input logic signed [63:0] acc,
                                      input int ws, input int frac);
    logic signed [63:0] r, hi, lo;
    rsat_t res;
    r        = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi       = (64'sd1 <<< (ws - 1)) - 64'sd1;
    lo       = -(64'sd1 <<< (ws - 1));
    res.y    = r;
    res.clip = 1'b0;
    if (r > hi) begin
      res.y    = hi;
      res.clip = 1'b1;
    end else if (r < lo) begin
      res.y    = lo;
      res.clip = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/dsp_mac.sv
// Single shared multiplier with a wide accumulator; clr restarts the sum with the
// current product, sub negates the product before it is added.
module dsp_mac #(
  parameter int WS   = 16,
  parameter int CW   = 16,
  parameter int ACCW = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   sub,
  input  logic signed [WS-1:0]   data,
  input  logic signed [CW-1:0]   coef,
  output logic signed [ACCW-1:0] acc_next
);

  localparam int PW = WS + CW;

  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] prod_ext, base, acc_q, acc_d;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    prod     = PW'(data) * PW'(coef);
    prod_ext = ACCW'(prod);
    base     = clr ? '0 : acc_q;
    acc_d    = acc_q;
    if (en)       acc_d = sub ? base - prod_ext : base + prod_ext;
    else if (clr) acc_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_next = acc_d;

endmodule

// File: rtl/dsp_biquad.sv
// Multi-channel direct-form-I biquad: one frame per request, five MAC steps per
// channel through a single shared multiplier, histories kept per channel.
import dsp_pkg::*;

module dsp_biquad #(
  parameter int WS   = 16,
  parameter int CW   = 16,
  parameter int FRAC = 14,
  parameter int NCH  = 2,
  parameter int ACCW = 40
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iValid,
  output logic              oReady,
  input  logic [NCH*WS-1:0] iIn,
  input  logic [5*CW-1:0]   iCoef,
  input  logic              iBypass,
  output logic              oValid,
  output logic [NCH*WS-1:0] oOut,
  output logic              oSat
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

  typedef logic signed [WS-1:0] smp_t;

  state_e               state_q, state_d;
  coef_e                tap_q, tap_d;
  logic [CHW-1:0]       ch_q, ch_d;
  smp_t                 x0_q [NCH], x0_d [NCH];
  smp_t                 x1_q [NCH], x1_d [NCH];
  smp_t                 x2_q [NCH], x2_d [NCH];
  smp_t                 y1_q [NCH], y1_d [NCH];
  smp_t                 y2_q [NCH], y2_d [NCH];
  smp_t                 res_q [NCH], res_d [NCH];
  logic signed [CW-1:0] coef_q [5], coef_d [5];
  logic                 bypass_q, bypass_d;
  logic                 valid_q, valid_d;
  logic                 sat_q, sat_d;
  logic [NCH*WS-1:0]    out_q, out_d;

  logic                 mac_clr, mac_en, mac_sub;
  smp_t                 mac_data;
  logic signed [CW-1:0] mac_coef;
  logic signed [ACCW-1:0] acc_next;
  rsat_t                rs;
  smp_t                 y_sat;

  dsp_mac #(.WS(WS), .CW(CW), .ACCW(ACCW)) u_mac (
    .clk      (iCLK),
    .rst      (iRST),
    .clr      (mac_clr),
    .en       (mac_en),
    .sub      (mac_sub),
    .data     (mac_data),
    .coef     (mac_coef),
    .acc_next (acc_next)
  );

  // Operand select: tap order b0*x0, b1*x1, b2*x2, -a1*y1, -a2*y2.
  always_comb begin
    mac_en   = (state_q == MAC);
    mac_clr  = mac_en && (tap_q == B0);
    mac_sub  = (tap_q == A1) || (tap_q == A2);
    mac_coef = coef_q[tap_q];
    unique case (tap_q)
      B0:      mac_data = x0_q[ch_q];
      B1:      mac_data = x1_q[ch_q];
      B2:      mac_data = x2_q[ch_q];
      A1:      mac_data = y1_q[ch_q];
      default: mac_data = y2_q[ch_q];
    endcase
    rs    = round_sat(64'(acc_next), WS, FRAC);
    y_sat = WS'(rs.y);
  end

  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    ch_d     = ch_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    y1_d     = y1_q;
    y2_d     = y2_q;
    res_d    = res_q;
    coef_d   = coef_q;
    bypass_d = bypass_q;
    sat_d    = sat_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iValid) begin
          state_d  = MAC;
          tap_d    = B0;
          ch_d     = '0;
          bypass_d = iBypass;
          for (int k = 0; k < NCH; k++) x0_d[k] = iIn[k*WS +: WS];
          for (int i = 0; i < 5; i++)   coef_d[i] = iCoef[i*CW +: CW];
        end
      end
      MAC: begin
        if (tap_q == A2) begin
          res_d[ch_q] = y_sat;
          if (rs.clip && !bypass_q) sat_d = 1'b1;
          tap_d = B0;
          if (ch_q == LAST_CH) state_d = DONE;
          else                 ch_d = ch_q + 1'b1;
        end else begin
          tap_d = coef_e'(tap_q + 3'd1);
        end
      end
      DONE: begin
        state_d = IDLE;
        valid_d = 1'b1;
        for (int k = 0; k < NCH; k++) begin
          if (bypass_q) begin
            out_d[k*WS +: WS] = x0_q[k];
            x1_d[k] = '0;
            x2_d[k] = '0;
            y1_d[k] = '0;
            y2_d[k] = '0;
          end else begin
            out_d[k*WS +: WS] = res_q[k];
            x2_d[k] = x1_q[k];
            x1_d[k] = x0_q[k];
            y2_d[k] = y1_q[k];
            y1_d[k] = res_q[k];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= IDLE;
      tap_q    <= B0;
      ch_q     <= '0;
      bypass_q <= 1'b0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
      out_q    <= '0;
      // NOTE: the history arrays feed the filter output, so they are reset like any other state.
      for (int k = 0; k < NCH; k++) begin
        x0_q[k]  <= '0;
        x1_q[k]  <= '0;
        x2_q[k]  <= '0;
        y1_q[k]  <= '0;
        y2_q[k]  <= '0;
        res_q[k] <= '0;
      end
      for (int i = 0; i < 5; i++) coef_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      ch_q     <= ch_d;
      bypass_q <= bypass_d;
      valid_q  <= valid_d;
      sat_q    <= sat_d;
      out_q    <= out_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      y1_q     <= y1_d;
      y2_q     <= y2_d;
      res_q    <= res_d;
      coef_q   <= coef_d;
    end
  end

  assign oReady = (state_q == IDLE);
  assign oValid = valid_q;
  assign oOut   = out_q;
  assign oSat   = sat_q;

endmodule

// File: tb/tb_dsp_biquad.sv
// Directed and randomized frames for dsp_biquad, compared against a per-channel
// difference-equation model evaluated with plain integer arithmetic.
module tb_dsp_biquad;
  import dsp_pkg::*;

  localparam int WS = 16, CW = 16, FRAC = 14, NCH = 2, ACCW = 40;
  localparam int LAT = 5 * NCH + 2;
  localparam longint ONE = 64'sd1 << FRAC;
  localparam longint HALF = 64'sd1 << (FRAC - 1);
  localparam longint YMAX = (64'sd1 << (WS - 1)) - 1;
  localparam longint YMIN = -(64'sd1 << (WS - 1));

  logic              iCLK = 1'b0;
  logic              iRST, iValid, iBypass;
  logic [NCH*WS-1:0] iIn;
  logic [5*CW-1:0]   iCoef;
  logic              oReady, oValid, oSat;
  logic [NCH*WS-1:0] oOut;

  int n_checks = 0;
  int n_pass   = 0;

  longint m_x1 [NCH], m_x2 [NCH], m_y1 [NCH], m_y2 [NCH];
  bit     m_sat;

  always #5 iCLK = ~iCLK;

  dsp_biquad #(.WS(WS), .CW(CW), .FRAC(FRAC), .NCH(NCH), .ACCW(ACCW)) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iValid  (iValid),
    .oReady  (oReady),
    .iIn     (iIn),
    .iCoef   (iCoef),
    .iBypass (iBypass),
    .oValid  (oValid),
    .oOut    (oOut),
    .oSat    (oSat)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [NCH*WS-1:0] frame2(input int c0, input int c1);
    dType s0, s1;
    s0 = dType'(c0);
    s1 = dType'(c1);
    return {s1, s0};
  endfunction

  function automatic logic [5*CW-1:0] coefs(input int b0, input int b1, input int b2,
                                            input int a1, input int a2);
    return {CW'(a2), CW'(a1), CW'(b2), CW'(b1), CW'(b0)};
  endfunction

  function automatic int rnd_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic longint floor_div(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_x1[k] = 0; m_x2[k] = 0; m_y1[k] = 0; m_y2[k] = 0;
    end
    m_sat = 1'b0;
  endtask

  // y = b0*x0 + b1*x1 + b2*x2 - a1*y1 - a2*y2, rounded to nearest and clamped.
  task automatic model_frame(input logic [NCH*WS-1:0] x, input logic [5*CW-1:0] c,
                             input bit byp, output logic [NCH*WS-1:0] y);
    longint cb [5];
    longint x0, acc, yy;
    for (int i = 0; i < 5; i++) cb[i] = longint'($signed(c[i*CW +: CW]));
    y = '0;
    for (int k = 0; k < NCH; k++) begin
      x0 = longint'($signed(x[k*WS +: WS]));
      if (byp) begin
        y[k*WS +: WS] = x[k*WS +: WS];
        m_x1[k] = 0; m_x2[k] = 0; m_y1[k] = 0; m_y2[k] = 0;
      end else begin
        acc = cb[0]*x0 + cb[1]*m_x1[k] + cb[2]*m_x2[k] - cb[3]*m_y1[k] - cb[4]*m_y2[k];
        yy  = floor_div(acc + HALF, ONE);
        if (yy > YMAX) begin yy = YMAX; m_sat = 1'b1; end
        if (yy < YMIN) begin yy = YMIN; m_sat = 1'b1; end
        y[k*WS +: WS] = WS'(yy);
        m_x2[k] = m_x1[k]; m_x1[k] = x0;
        m_y2[k] = m_y1[k]; m_y1[k] = yy;
      end
    end
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!oReady && n < 4 * LAT) begin
      @(negedge iCLK);
      n++;
    end
    ok = oReady;
  endtask

  task automatic do_reset(input string tag, input bit valid_in_reset);
    iRST = 1'b1;
    iValid = valid_in_reset;
    @(negedge iCLK);
    iRST = 1'b0;
    iValid = 1'b0;
    check({tag, "_ready"}, oReady, 1);
    check({tag, "_valid"}, oValid, 0);
    check({tag, "_out"}, oOut, 0);
    check({tag, "_sat"}, oSat, 0);
    model_reset();
  endtask

  // Offers one frame, scrambles all inputs right after acceptance, then checks
  // latency, output, sticky flag and the single-cycle valid pulse.
  task automatic send(input string tag, input logic [NCH*WS-1:0] x, input logic [5*CW-1:0] c,
                      input bit byp, output logic [NCH*WS-1:0] got);
    logic [NCH*WS-1:0] exp;
    int lat;
    bit ok;
    iIn = x; iCoef = c; iBypass = byp; iValid = 1'b1;
    wait_ready(ok);
    check({tag, "_accept"}, ok, 1);
    model_frame(x, c, byp, exp);
    lat = 0;
    do begin
      @(negedge iCLK);
      lat++;
      if (lat == 1) begin
        iValid = 1'b0;
        iIn = NCH*WS'($urandom);
        iCoef = coefs(rnd_s16(), rnd_s16(), rnd_s16(), rnd_s16(), rnd_s16());
        iBypass = 1'($urandom_range(0, 1));
      end
    end while (!oValid && lat < 4 * LAT);
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_out"}, oOut, exp);
    check({tag, "_sat"}, oSat, m_sat);
    got = oOut;
    @(negedge iCLK);
    check({tag, "_pulse"}, oValid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  initial begin
    logic [NCH*WS-1:0] got, e1, e2;
    logic [5*CW-1:0] c, c1, c2;
    int din [3], dexp [3], rin [4], rexp [4];
    int n, seen;
    bit ok;

    iRST = 1'b1; iValid = 1'b0; iBypass = 1'b0; iIn = '0; iCoef = '0;
    do_reset("por", 1'b0);

    // Identity filter
    c = coefs(16384, 0, 0, 0, 0);
    send("id0", frame2(1000, -2000), c, 1'b0, got);
    check("id0_lit", got, frame2(1000, -2000));
    send("id1", frame2(32767, -32768), c, 1'b0, got);
    check("id1_lit", got, frame2(32767, -32768));

    // One-sample delay through b1
    do_reset("rst_dly", 1'b0);
    c = coefs(0, 16384, 0, 0, 0);
    din = '{500, 700, 900};
    dexp = '{0, 500, 700};
    for (int i = 0; i < 3; i++) begin
      send("dly", frame2(din[i], rnd_s16()), c, 1'b0, got);
      check("dly_lit", got[WS-1:0], WS'(dexp[i]));
    end

    // First-order recursion with a1 = -0.5
    do_reset("rst_rec", 1'b0);
    c = coefs(16384, 0, 0, -8192, 0);
    rin = '{16000, 0, 0, 0};
    rexp = '{16000, 8000, 4000, 2000};
    for (int i = 0; i < 4; i++) begin
      send("rec", frame2(rin[i], 0), c, 1'b0, got);
      check("rec_ch0", got[WS-1:0], WS'(rexp[i]));
      check("rec_ch1", got[NCH*WS-1:WS], 0);
    end

    // Saturation and sticky flag
    do_reset("rst_sat", 1'b0);
    send("sat", frame2(30000, 0), coefs(32767, 0, 0, 0, 0), 1'b0, got);
    check("sat_ch0", got[WS-1:0], 16'h7fff);
    check("sat_flag", oSat, 1);
    for (int i = 0; i < 2; i++) begin
      send("sat_hold", frame2(rnd_s16() / 4, rnd_s16() / 4), coefs(16384, 0, 0, 0, 0), 1'b0, got);
      check("sat_sticky", oSat, 1);
    end
    do_reset("rst_sat_clr", 1'b1);

    // Randomized coefficients, samples and bypass frames
    for (int i = 0; i < 24; i++) begin
      c = coefs(rnd_s16(), rnd_s16(), rnd_s16(),
                int'($urandom_range(0, 16384)) - 8192, int'($urandom_range(0, 16384)) - 8192);
      send("rnd", NCH*WS'($urandom), c, ($urandom_range(0, 4) == 0), got);
    end

    // Continuous iValid: acceptance spacing, no queuing, mid-frame coefficient change
    do_reset("rst_hs", 1'b0);
    c1 = coefs(16384, 0, 0, 0, 0);
    c2 = coefs(8192, 0, 0, 0, 0);
    iIn = frame2(111, -222); iCoef = c1; iBypass = 1'b0; iValid = 1'b1;
    wait_ready(ok);
    check("hs_first_accept", ok, 1);
    model_frame(frame2(111, -222), c1, 1'b0, e1);
    n = 0; seen = 0;
    do begin
      @(negedge iCLK);
      n++;
      if (n == 3) begin iIn = frame2(4000, -4000); iCoef = c2; end
      if (oReady && !oValid) seen++;
    end while (!oValid && n < 4 * LAT);
    check("hs_lat1", n, LAT);
    check("hs_out1", oOut, e1);
    check("hs_out1_lit", oOut, frame2(111, -222));
    check("hs_no_early_ready", seen, 0);
    check("hs_second_accept", oReady, 1);
    model_frame(frame2(4000, -4000), c2, 1'b0, e2);
    n = 0;
    do begin
      @(negedge iCLK);
      n++;
      iValid = 1'b0;
    end while (!oValid && n < 4 * LAT);
    check("hs_lat2", n, LAT);
    check("hs_out2", oOut, e2);
    check("hs_out2_lit", oOut, frame2(2000, -2000));

    // Reset four cycles into a frame aborts it and clears history
    do_reset("rst_abort_pre", 1'b0);
    c = coefs(0, 16384, 0, 0, 0);
    send("abort_pre", frame2(500, 300), c, 1'b0, got);
    check("abort_pre_lit", got, 0);
    iIn = frame2(700, 100); iCoef = c; iBypass = 1'b0; iValid = 1'b1;
    wait_ready(ok);
    check("abort_accept", ok, 1);
    repeat (4) begin
      @(negedge iCLK);
      iValid = 1'b0;
    end
    do_reset("abort_rst", 1'b1);
    seen = 0;
    repeat (2 * LAT) begin
      @(negedge iCLK);
      if (oValid) seen++;
    end
    check("abort_no_valid", seen, 0);
    send("abort_post", frame2(900, 50), c, 1'b0, got);
    check("abort_post_lit", got, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
